// File: rtl/booth_r4_seq_mult.sv
// Sequential radix-4 Booth multiplier: one partial product per cycle,
// signed/unsigned per operation, valid/ready handshake on both sides.
module booth_r4_seq_mult #(
  parameter int unsigned WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     x,
  input  logic [WIDTH-1:0]     y,
  input  logic                 signed_mode,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [2*WIDTH-1:0]   product,
  output logic                 busy
);

  localparam int unsigned EW   = WIDTH + 2;
  localparam int unsigned SW   = EW + 1;
  localparam int unsigned AW   = 2 * WIDTH + 4;
  localparam int unsigned PW   = 2 * WIDTH;
  localparam int unsigned ITER = WIDTH / 2 + 1;
  localparam int unsigned CW   = $clog2(ITER + 1);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] CALC = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]    state, state_d;
  logic [EW-1:0] xr;
  logic [AW-1:0] acc, acc_step;
  logic          y_m1;
  logic [CW-1:0] cnt;
  logic          last_step;

  logic [EW-1:0] x_ext, y_ext;
  logic [2:0]    trip;
  logic [SW-1:0] hi_ext, mag, sum;
  logic          neg;
  logic [AW:0]   wide, wide_sh;

  assign x_ext     = {{2{signed_mode & x[WIDTH-1]}}, x};
  assign y_ext     = {{2{signed_mode & y[WIDTH-1]}}, y};
  assign last_step = (cnt == CW'(ITER - 1));

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state;
    case (state)
      IDLE:    if (in_valid)  state_d = CALC;
      CALC:    if (last_step) state_d = DONE;
      DONE:    if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // One Booth step: recode triplet, add partial product into the high half, shift by 2
  always_comb begin
    trip   = {acc[1:0], y_m1};
    hi_ext = {acc[AW-1], acc[AW-1:EW]};
    neg    = 1'b0;
    mag    = '0;
    case (trip)
      3'b001, 3'b010: mag = {xr[EW-1], xr};
      3'b011:         mag = {xr, 1'b0};
      3'b100: begin   mag = {xr, 1'b0};         neg = 1'b1; end
      3'b101, 3'b110: begin mag = {xr[EW-1], xr}; neg = 1'b1; end
      default: ;
    endcase
    sum      = hi_ext + (neg ? ~mag : mag) + SW'(neg);
    wide     = {sum, acc[EW-1:0]};
    wide_sh  = $signed(wide) >>> 2;
    acc_step = AW'(wide_sh);
  end

  // Datapath and registered handshake outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      xr        <= '0;
      acc       <= '0;
      y_m1      <= 1'b0;
      cnt       <= '0;
      product   <= '0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      busy      <= 1'b0;
    end else begin
      in_ready  <= (state_d == IDLE);
      out_valid <= (state_d == DONE);
      busy      <= (state_d != IDLE);
      if (state == IDLE && in_valid) begin
        xr   <= x_ext;
        acc  <= {EW'(0), y_ext};
        y_m1 <= 1'b0;
        cnt  <= '0;
      end else if (state == CALC) begin
        acc  <= acc_step;
        y_m1 <= acc[1];
        cnt  <= cnt + CW'(1);
        if (last_step) product <= PW'(acc_step);
      end
    end
  end

endmodule
